nes_pad_array: RTL and testbench

- Parametrised multi-controller serial gamepad reader; successor to the single NES pad reader.
- One shared latch and one shared data clock drive CHANNELS pads; each pad has its own serial data line.
- Reads BITS bits per pad (8 for NES, 12/16 for SNES) on a free-running poll period or on demand.
- Presents a registered, active-high button vector to the CPU/APU glue.

---
 rtl/nes_pad_pkg.sv | 33 +++
 rtl/nes_pad_sync.sv | 26 ++
 rtl/nes_pad_array.sv | 205 ++++++++++++++++++++
 tb/tb_nes_pad_array.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_pkg.sv
// Shared definitions for the multi-pad serial gamepad reader: FSM encoding
// and button bit positions within one pad's word.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_UPDATE = 3'd4
  } pad_state_e;

  // NES button order as shifted out by the pad
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // SNES extras
  localparam int unsigned BTN_X = 9;
  localparam int unsigned BTN_L = 10;
  localparam int unsigned BTN_R = 11;

  // Cycles from latch rise to the end of the update cycle
  function automatic int unsigned frame_cycles(input int unsigned half, input int unsigned bits);
    return 2 * half + 2 * half * bits + 1;
  endfunction

endpackage

// File: rtl/nes_pad_sync.sv
// Two-flop synchroniser for the asynchronous pad data lines.
module nes_pad_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= data_i;
      sync_q <= meta_q;
    end
  end

  assign data_o = sync_q;

endmodule

// File: rtl/nes_pad_array.sv
// Multi-controller serial gamepad reader: shared latch/clock, one data line per pad.
// Define NES_PAD_EDGE_EN to add the o_pressed newly-pressed output.
module nes_pad_array
  import nes_pad_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned BITS      = 8,
  parameter int unsigned CLK_HZ    = 27000000,
  parameter int unsigned HALF_US   = 6,
  parameter int unsigned POLL_HZ   = 60,
  parameter int unsigned AUTO_POLL = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [CHANNELS-1:0]      i_serial_data,
  output logic                     o_data_latch,
  output logic                     o_data_clock,
  output logic [CHANNELS*BITS-1:0] o_button_state,
  output logic                     o_data_available,
`ifdef NES_PAD_EDGE_EN
  output logic [CHANNELS*BITS-1:0] o_pressed,
`endif
  output logic                     o_busy
);

  localparam int unsigned H       = CLK_HZ / 1000000 * HALF_US;
  localparam int unsigned P       = CLK_HZ / POLL_HZ;
  localparam int unsigned F       = frame_cycles(H, BITS);
  localparam int unsigned PHASE_W = $clog2(2 * H);
  localparam int unsigned BIT_W   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned POLL_W  = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned VEC_W   = CHANNELS * BITS;

  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * H - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(H - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS - 1);

  if (H < 4) begin : g_bad_half
    $error("nes_pad_array: half clock period H=%0d must be at least 4 cycles", H);
  end
  if (AUTO_POLL != 0 && P <= F) begin : g_bad_poll
    $error("nes_pad_array: poll period P=%0d must exceed frame length F=%0d", P, F);
  end

  pad_state_e                         state_q, state_d;
  logic [PHASE_W-1:0]                 phase_q, phase_d;
  logic [BIT_W-1:0]                   bit_q, bit_d;
  logic [CHANNELS-1:0][BITS-1:0]      shift_q, shift_d;
  logic [VEC_W-1:0]                   button_q, button_d;
  logic                               latch_q, latch_d;
  logic                               dclk_q, dclk_d;
  logic                               busy_q, busy_d;
  logic                               avail_q, avail_d;
  logic [CHANNELS-1:0]                sync_c;
  logic                               tick_c;

  nes_pad_sync #(
    .WIDTH (CHANNELS)
  ) u_sync (
    .clk    (i_clk),
    .rst_n  (i_rst),
    .data_i (i_serial_data),
    .data_o (sync_c)
  );

  // Free-running poll counter; count 0 is the tick, so a frame starts right after reset
  if (AUTO_POLL != 0) begin : g_poll
    logic [POLL_W-1:0] poll_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        poll_q <= '0;
      end else if (poll_q == POLL_W'(P - 1)) begin
        poll_q <= '0;
      end else begin
        poll_q <= poll_q + POLL_W'(1);
      end
    end

    assign tick_c = (poll_q == '0);
  end else begin : g_no_poll
    assign tick_c = 1'b0;
  end

  // Next state; the pad's first bit enters the MSB and ends at bit 0 after BITS shifts
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    button_d = button_q;

    case (state_q)
      ST_IDLE: begin
        if (tick_c || i_start) begin
          state_d = ST_LATCH;
          phase_d = '0;
          shift_d = '0;
        end
      end
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = ST_LOW;
          phase_d = '0;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_LOW: begin
        if (phase_q == HALF_LAST) begin
          for (int c = 0; c < CHANNELS; c++) begin
            shift_d[c] = {~sync_c[c], shift_q[c][BITS-1:1]};
          end
          state_d = ST_HIGH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_HIGH: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_UPDATE;
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pin outputs follow the next state so they are flop-driven and aligned with state_q
    latch_d = (state_d == ST_LATCH);
    dclk_d  = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
    avail_d = (state_d == ST_UPDATE);
    if (state_d == ST_UPDATE) begin
      button_d = shift_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      button_q <= '0;
      latch_q  <= 1'b0;
      dclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      button_q <= button_d;
      latch_q  <= latch_d;
      dclk_q   <= dclk_d;
      busy_q   <= busy_d;
      avail_q  <= avail_d;
    end
  end

`ifdef NES_PAD_EDGE_EN
  // Buttons pressed in this frame that were released in the previous one
  logic [VEC_W-1:0] pressed_q, pressed_d;

  always_comb begin
    pressed_d = '0;
    if (state_d == ST_UPDATE) begin
      pressed_d = shift_d & ~button_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pressed_q <= '0;
    end else begin
      pressed_q <= pressed_d;
    end
  end

  assign o_pressed = pressed_q;
`endif

  assign o_data_latch     = latch_q;
  assign o_data_clock     = dclk_q;
  assign o_button_state   = button_q;
  assign o_data_available = avail_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_nes_pad_array.sv
// Bench for nes_pad_array: auto-poll instance with behavioural pads and a
// frame scoreboard, plus an on-demand instance for start/busy timing.
module tb_nes_pad_array;
  import nes_pad_pkg::*;

  logic             clk = 1'b0;
  logic             rst_a_n, rst_m_n;
  logic             start_a, start_m;
  logic [1:0]       ser_a;
  logic [1:0]       ser_m;
  logic             lat_a, ck_a, avail_a, busy_a;
  logic             lat_m, ck_m, avail_m, busy_m;
  logic [15:0]      button_a, button_m;
`ifdef NES_PAD_EDGE_EN
  logic [15:0]      pressed_a, pressed_m;
`endif

  logic [1:0][7:0]  pad_a;
  logic [1:0][7:0]  snap_a = '0;
  logic [3:0]       idx_a = 4'd8;
  logic             ck_a_prev = 1'b0;
  logic [15:0]      exp_a_q[$];
  int               cyc_a = 0;
  int               cyc_m = 0;
  int               n_checks = 0;
  int               n_pass = 0;
  logic             m_done = 1'b0;

  always #5 clk = ~clk;

  nes_pad_array #(
    .CHANNELS (2), .BITS (8), .CLK_HZ (1000000), .HALF_US (6), .POLL_HZ (1000), .AUTO_POLL (1)
  ) u_dut_a (
    .i_clk            (clk),
    .i_rst            (rst_a_n),
    .i_start          (start_a),
    .i_serial_data    (ser_a),
    .o_data_latch     (lat_a),
    .o_data_clock     (ck_a),
    .o_button_state   (button_a),
    .o_data_available (avail_a),
`ifdef NES_PAD_EDGE_EN
    .o_pressed        (pressed_a),
`endif
    .o_busy           (busy_a)
  );

  nes_pad_array #(
    .CHANNELS (2), .BITS (8), .CLK_HZ (1000000), .HALF_US (6), .POLL_HZ (1000), .AUTO_POLL (0)
  ) u_dut_m (
    .i_clk            (clk),
    .i_rst            (rst_m_n),
    .i_start          (start_m),
    .i_serial_data    (ser_m),
    .o_data_latch     (lat_m),
    .o_data_clock     (ck_m),
    .o_button_state   (button_m),
    .o_data_available (avail_m),
`ifdef NES_PAD_EDGE_EN
    .o_pressed        (pressed_m),
`endif
    .o_busy           (busy_m)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  always @(posedge clk or negedge rst_a_n)
    if (!rst_a_n) cyc_a <= 0;
    else          cyc_a <= cyc_a + 1;

  always @(posedge clk or negedge rst_m_n)
    if (!rst_m_n) cyc_m <= 0;
    else          cyc_m <= cyc_m + 1;

  // Pad model: latch snapshots buttons, each clock rise advances to the next bit
  always @(posedge clk) begin
    if (lat_a) begin
      snap_a <= pad_a;
      idx_a  <= 4'd0;
    end else if (ck_a && !ck_a_prev && idx_a != 4'd8) begin
      idx_a  <= idx_a + 4'd1;
    end
    ck_a_prev <= ck_a;
  end

  always_comb begin
    for (int c = 0; c < 2; c++) ser_a[c] = idx_a[3] ? 1'b1 : ~snap_a[c][idx_a[2:0]];
  end

  assign ser_m = 2'b11;

  // Scoreboard and waveform-shape monitor for the auto-poll instance
  logic        mon_lat_d, mon_ck_d, mon_avail_d;
  int          mon_lat_cnt, mon_pulses, mon_hi_len;
  logic [15:0] mon_prev_exp;
  always @(negedge clk) begin
    logic [15:0] exp;
    if (!rst_a_n) begin
      exp_a_q.delete();
      mon_lat_d = 1'b0; mon_ck_d = 1'b0; mon_avail_d = 1'b0;
      mon_lat_cnt = 0; mon_pulses = 0; mon_hi_len = 0;
      mon_prev_exp = '0;
    end else begin
      if (lat_a && !mon_lat_d) begin
        exp_a_q.push_back(pad_a);
        mon_lat_cnt = 0;
        mon_pulses  = 0;
      end
      if (lat_a) mon_lat_cnt++;
      if (ck_a && !mon_ck_d) begin
        mon_pulses++;
        mon_hi_len = 0;
      end
      if (ck_a) mon_hi_len++;
      if (!ck_a && mon_ck_d) check("clk_high_len", 32'(mon_hi_len), 32'd6);
`ifdef NES_PAD_EDGE_EN
      if (mon_avail_d) check("pressed_idle", 32'(pressed_a), 32'd0);
`endif
      if (avail_a) begin
        check("sb_depth", 32'(exp_a_q.size()), 32'd1);
        check("latch_cycles", 32'(mon_lat_cnt), 32'd12);
        check("clk_pulses", 32'(mon_pulses), 32'd8);
        if (exp_a_q.size() > 0) begin
          exp = exp_a_q.pop_front();
          check("sb_buttons", 32'(button_a), 32'(exp));
`ifdef NES_PAD_EDGE_EN
          check("pressed", 32'(pressed_a), 32'(exp & ~mon_prev_exp));
`endif
          mon_prev_exp = exp;
        end
      end
      mon_lat_d   = lat_a;
      mon_ck_d    = ck_a;
      mon_avail_d = avail_a;
    end
  end

  // Timing monitor for the on-demand instance
  int m_first_busy = -1, m_last_busy = -1, m_busy_cnt = 0, m_avail_cnt = 0;
  int m_avail_cyc = -1, m_lat_cnt = 0, m_pulses = 0;
  logic m_ck_d = 1'b0;
  always @(negedge clk) begin
    if (rst_m_n) begin
      if (busy_m) begin
        if (m_first_busy < 0) m_first_busy = cyc_m;
        m_last_busy = cyc_m;
        m_busy_cnt++;
      end
      if (avail_m) begin
        m_avail_cnt++;
        m_avail_cyc = cyc_m;
`ifdef NES_PAD_EDGE_EN
        check("m_pressed", 32'(pressed_m), 32'd0);
`endif
      end
      if (lat_m) m_lat_cnt++;
      if (ck_m && !m_ck_d) m_pulses++;
      m_ck_d = ck_m;
    end
  end

  initial begin
    @(posedge rst_m_n);
    while (cyc_m < 50) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    while (cyc_m < 60) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    while (cyc_m < 400) @(negedge clk);
    check("m_first_busy", 32'(m_first_busy), 32'd51);
    check("m_last_busy", 32'(m_last_busy), 32'd159);
    check("m_busy_cnt", 32'(m_busy_cnt), 32'd109);
    check("m_avail_cnt", 32'(m_avail_cnt), 32'd1);
    check("m_avail_cyc", 32'(m_avail_cyc), 32'd159);
    check("m_latch_cycles", 32'(m_lat_cnt), 32'd12);
    check("m_clk_pulses", 32'(m_pulses), 32'd8);
    check("m_absent_pads", 32'(button_m), 32'd0);
    m_done = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int rises;
    logic prev;
    rst_a_n = 1'b0;
    rst_m_n = 1'b0;
    start_a = 1'b0;
    start_m = 1'b0;
    pad_a[0] = 8'((1 << BTN_A) | (1 << BTN_START));
    pad_a[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_latch", 32'(lat_a), 32'd0);
    check("rst_clock", 32'(ck_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_avail", 32'(avail_a), 32'd0);
    check("rst_buttons", 32'(button_a), 32'd0);
    rst_a_n = 1'b1;
    rst_m_n = 1'b1;

    // First frame: starts on the first cycle out of reset
    t = 0;
    while (!avail_a && t < 300) begin @(negedge clk); t++; end
    check("f1_avail_cyc", 32'(cyc_a), 32'd109);
    check("f1_buttons", 32'(button_a), 32'h0009);
    @(negedge clk);
    check("avail_one_cycle", 32'(avail_a), 32'd0);
    check("idle_after_update", 32'(busy_a), 32'd0);
    pad_a[1] = 8'(1 << BTN_RIGHT);

    // Poll tick coinciding with i_start still gives one frame at the normal period
    t = 0;
    while (cyc_a < 1000 && !lat_a && t < 1200) begin @(negedge clk); t++; end
    check("no_early_latch", 32'(lat_a), 32'd0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("poll_latch_cyc", 32'(cyc_a), 32'd1001);
    check("poll_latch_high", 32'(lat_a), 32'd1);
    repeat (40) @(negedge clk);
    check("mid_frame_hold", 32'(button_a[8+BTN_RIGHT]), 32'd0);
    t = 0;
    while (!avail_a && t < 300) begin @(negedge clk); t++; end
    check("right_follows", 32'(button_a[8+BTN_RIGHT]), 32'd1);
    pad_a[1] = 8'h00;

    // Third frame: reset in the middle of HIGH(3)
    t = 0; rises = 0; prev = ck_a;
    while (!(rises == 4 && ck_a) && t < 2000) begin
      @(negedge clk);
      if (ck_a && !prev) rises++;
      prev = ck_a;
      t++;
    end
    check("reached_high3", 32'(rises), 32'd4);
    repeat (2) @(negedge clk);
    #1 rst_a_n = 1'b0;
    #1;
    check("async_rst_latch", 32'(lat_a), 32'd0);
    check("async_rst_clock", 32'(ck_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_buttons", 32'(button_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    t = 0;
    while (!avail_a && t < 300) begin @(negedge clk); t++; end
    check("restart_avail_cyc", 32'(cyc_a), 32'd109);
    check("restart_buttons", 32'(button_a), 32'h0009);
    repeat (5) @(negedge clk);

    t = 0;
    while (!m_done && t < 5000) begin @(negedge clk); t++; end
    check("m_sequence_done", 32'(m_done), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
